// File: rtl/intersection_pkg.sv
// intersection_pkg: shared state codes, lamp bundle and default phase
// durations for the two-road intersection controller and its bench.
package intersection_pkg;

   localparam logic [3:0] S_OFF       = 4'd0;
   localparam logic [3:0] S_NS_GREEN  = 4'd1;
   localparam logic [3:0] S_NS_YELLOW = 4'd2;
   localparam logic [3:0] S_ALLRED1   = 4'd3;
   localparam logic [3:0] S_EW_GREEN  = 4'd4;
   localparam logic [3:0] S_EW_YELLOW = 4'd5;
   localparam logic [3:0] S_ALLRED2   = 4'd6;
   localparam logic [3:0] S_PED_WALK  = 4'd7;
   localparam logic [3:0] S_FLASH     = 4'd8;

   localparam int T_GREEN_DEF    = 30;
   localparam int T_YELLOW_DEF   = 10;
   localparam int T_ALLRED_DEF   = 3;
   localparam int T_PED_DEF      = 20;
   localparam int FLASH_HALF_DEF = 5;
   localparam int TW_DEF         = 8;

   typedef struct packed {
      logic red;
      logic yellow;
      logic green;
   } lamp_t;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: TW-bit up counter with synchronous clear and a
// terminal-count flag (tc = count == tc_val). Ports: clk, rst, clr, tc_val, tc.
module phase_timer
   import intersection_pkg::*;
#(
   parameter int TW = TW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [TW-1:0] tc_val,
   output logic          tc
);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   always_comb begin
      count_d = clr ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == tc_val);

endmodule

// File: rtl/intersection_fsm.sv
// intersection_fsm: NS/EW intersection controller with all-red clearance,
// latched pedestrian walk phase and flashing-yellow mode.
// Ports: clk, rst, enable, flash_mode, ped_req -> NS/EW lamps, walk,
// ped_pending, state_out (debug state code).
module intersection_fsm
   import intersection_pkg::*;
#(
   parameter int T_GREEN    = T_GREEN_DEF,
   parameter int T_YELLOW   = T_YELLOW_DEF,
   parameter int T_ALLRED   = T_ALLRED_DEF,
   parameter int T_PED      = T_PED_DEF,
   parameter int FLASH_HALF = FLASH_HALF_DEF,
   parameter int TW         = TW_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       flash_mode,
   input  logic       ped_req,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_pending,
   output logic [3:0] state_out
);

   logic [3:0]    state_q;
   logic [3:0]    state_d;
   logic          ped_pending_q;
   logic          ped_pending_d;
   logic          blink_q;
   logic          blink_d;
   logic [TW-1:0] tc_val;
   logic          tc;
   logic          timer_clr;
   logic          ped_set;
   logic          ped_clr;
   lamp_t         ns_l;
   lamp_t         ew_l;

   // Terminal count for the current phase; exit happens when timer == T-1.
   always_comb begin
      tc_val = '0;
      case (state_q)
         S_NS_GREEN,  S_EW_GREEN:  tc_val = TW'(T_GREEN - 1);
         S_NS_YELLOW, S_EW_YELLOW: tc_val = TW'(T_YELLOW - 1);
         S_ALLRED1,   S_ALLRED2:   tc_val = TW'(T_ALLRED - 1);
         S_PED_WALK:               tc_val = TW'(T_PED - 1);
         S_FLASH:                  tc_val = TW'(FLASH_HALF - 1);
         default:                  tc_val = '0;
      endcase
   end

   // In FLASH the timer wraps at each blink toggle.
   assign timer_clr = !enable
                    || (state_d != state_q)
                    || ((state_q == S_FLASH) && tc);

   phase_timer #(
      .TW(TW)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (timer_clr),
      .tc_val (tc_val),
      .tc     (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_OFF;
         ped_pending_q <= 1'b0;
         blink_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ped_pending_q <= ped_pending_d;
         blink_q       <= blink_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q > S_FLASH) begin
         state_d = S_OFF;
      end else if (!enable) begin
         state_d = S_OFF;
      end else if (flash_mode) begin
         state_d = S_FLASH;
      end else begin
         case (state_q)
            S_OFF, S_FLASH: state_d = S_ALLRED2;
            S_NS_GREEN:     if (tc) state_d = S_NS_YELLOW;
            S_NS_YELLOW:    if (tc) state_d = S_ALLRED1;
            S_ALLRED1:      if (tc) state_d = S_EW_GREEN;
            S_EW_GREEN:     if (tc) state_d = S_EW_YELLOW;
            S_EW_YELLOW:    if (tc) state_d = S_ALLRED2;
            S_ALLRED2:
               if (tc) state_d = ped_pending_q ? S_PED_WALK : S_NS_GREEN;
            S_PED_WALK:     if (tc) state_d = S_NS_GREEN;
            default:        state_d = S_OFF;
         endcase
      end

      // Clear beats set so a press during the walk entry is not kept.
      ped_set = ped_req
              && !(state_q inside {S_OFF, S_FLASH, S_PED_WALK});
      ped_clr = !enable
              || ((state_d == S_PED_WALK) && (state_q != S_PED_WALK));
      ped_pending_d = ped_clr ? 1'b0 : (ped_pending_q | ped_set);

      blink_d = blink_q;
      if (state_d == S_FLASH) begin
         if (state_q != S_FLASH) begin
            blink_d = 1'b1;
         end else if (tc) begin
            blink_d = ~blink_q;
         end
      end
   end

   always_comb begin
      ns_l = '0;
      ew_l = '0;
      walk = 1'b0;
      case (state_q)
         S_NS_GREEN: begin
            ns_l.green = 1'b1;
            ew_l.red   = 1'b1;
         end
         S_NS_YELLOW: begin
            ns_l.yellow = 1'b1;
            ew_l.red    = 1'b1;
         end
         S_EW_GREEN: begin
            ew_l.green = 1'b1;
            ns_l.red   = 1'b1;
         end
         S_EW_YELLOW: begin
            ew_l.yellow = 1'b1;
            ns_l.red    = 1'b1;
         end
         S_ALLRED1, S_ALLRED2: begin
            ns_l.red = 1'b1;
            ew_l.red = 1'b1;
         end
         S_PED_WALK: begin
            ns_l.red = 1'b1;
            ew_l.red = 1'b1;
            walk     = 1'b1;
         end
         S_FLASH: begin
            ns_l.yellow = blink_q;
            ew_l.yellow = blink_q;
         end
         default: begin
            ns_l = '0;
            ew_l = '0;
         end
      endcase
   end

   assign ns_red      = ns_l.red;
   assign ns_yellow   = ns_l.yellow;
   assign ns_green    = ns_l.green;
   assign ew_red      = ew_l.red;
   assign ew_yellow   = ew_l.yellow;
   assign ew_green    = ew_l.green;
   assign ped_pending = ped_pending_q;
   assign state_out   = state_q;

endmodule

// File: tb/tb_intersection_fsm.sv
// tb_intersection_fsm: directed scenarios plus random run, each cycle
// compared against a phase/age reference model of the controller.
module tb_intersection_fsm;
   import intersection_pkg::*;

   localparam int TG = 4;
   localparam int TY = 2;
   localparam int TA = 1;
   localparam int TP = 3;
   localparam int FH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       flash_mode = 1'b0;
   logic       ped_req = 1'b0;
   logic       ns_red, ns_yellow, ns_green;
   logic       ew_red, ew_yellow, ew_green;
   logic       walk, ped_pending;
   logic [3:0] state_out;

   int n_chk = 0;
   int n_fail = 0;

   int m_st = 0;
   int m_age = 0;
   int m_fk = 0;
   bit m_pend = 1'b0;

   intersection_fsm #(
      .T_GREEN    (TG),
      .T_YELLOW   (TY),
      .T_ALLRED   (TA),
      .T_PED      (TP),
      .FLASH_HALF (FH),
      .TW         (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .flash_mode  (flash_mode),
      .ped_req     (ped_req),
      .ns_red      (ns_red),
      .ns_yellow   (ns_yellow),
      .ns_green    (ns_green),
      .ew_red      (ew_red),
      .ew_yellow   (ew_yellow),
      .ew_green    (ew_green),
      .walk        (walk),
      .ped_pending (ped_pending),
      .state_out   (state_out)
   );

   always #5 clk = ~clk;

   function automatic int dur(int s);
      case (s)
         S_NS_GREEN, S_EW_GREEN:   return TG;
         S_NS_YELLOW, S_EW_YELLOW: return TY;
         S_ALLRED1, S_ALLRED2:     return TA;
         S_PED_WALK:               return TP;
         default:                  return 0;
      endcase
   endfunction

   function automatic int seq_next(int s, bit p);
      case (s)
         S_NS_GREEN:  return S_NS_YELLOW;
         S_NS_YELLOW: return S_ALLRED1;
         S_ALLRED1:   return S_EW_GREEN;
         S_EW_GREEN:  return S_EW_YELLOW;
         S_EW_YELLOW: return S_ALLRED2;
         S_ALLRED2:   return p ? S_PED_WALK : S_NS_GREEN;
         S_PED_WALK:  return S_NS_GREEN;
         default:     return S_OFF;
      endcase
   endfunction

   // {ns r,y,g, ew r,y,g, walk}
   function automatic logic [6:0] exp_lamps();
      logic b;
      b = ((m_fk / FH) % 2) == 0;
      case (m_st)
         S_NS_GREEN:           return 7'b001_100_0;
         S_NS_YELLOW:          return 7'b010_100_0;
         S_EW_GREEN:           return 7'b100_001_0;
         S_EW_YELLOW:          return 7'b100_010_0;
         S_ALLRED1, S_ALLRED2: return 7'b100_100_0;
         S_PED_WALK:           return 7'b100_100_1;
         S_FLASH:              return {1'b0, b, 2'b00, b, 2'b00};
         default:              return 7'b0;
      endcase
   endfunction

   // Advance the model across the coming clock edge using current inputs.
   task automatic model_step();
      int nx;
      if (rst) begin
         m_st = S_OFF;
         m_age = 0;
         m_pend = 1'b0;
         m_fk = 0;
         return;
      end
      if (!enable) nx = S_OFF;
      else if (flash_mode) nx = S_FLASH;
      else if (m_st == S_OFF || m_st == S_FLASH) nx = S_ALLRED2;
      else if (m_age + 1 == dur(m_st)) nx = seq_next(m_st, m_pend);
      else nx = m_st;
      if (nx == S_FLASH) m_fk = (m_st == S_FLASH) ? m_fk + 1 : 0;
      if (!enable || (nx == S_PED_WALK && m_st != S_PED_WALK))
         m_pend = 1'b0;
      else if (ped_req && !(m_st inside {S_OFF, S_FLASH, S_PED_WALK}))
         m_pend = 1'b1;
      m_age = (nx == m_st) ? m_age + 1 : 0;
      m_st = nx;
   endtask

   task automatic chk(string tag, int obs, int exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t",
                tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      logic [6:0] lamps;
      model_step();
      @(negedge clk);
      lamps = {ns_red, ns_yellow, ns_green,
               ew_red, ew_yellow, ew_green, walk};
      chk("state", int'(state_out), m_st);
      chk("lamps", int'(lamps), int'(exp_lamps()));
      chk("pend", int'(ped_pending), int'(m_pend));
      chk("ns_one", int'(ns_red) + int'(ns_yellow) + int'(ns_green) <= 1, 1);
      chk("ew_one", int'(ew_red) + int'(ew_yellow) + int'(ew_green) <= 1, 1);
      chk("ns_g_safe", int'(!ns_green || (ew_red && !ew_yellow)), 1);
      chk("ew_g_safe", int'(!ew_green || (ns_red && !ns_yellow)), 1);
   endtask

   task automatic wait_state(int code, int lim);
      for (int i = 0; i < lim; i++) begin
         if (int'(state_out) == code) return;
         cyc();
      end
      chk("wait_state_timeout", int'(state_out), code);
   endtask

   int seq_code [6] = '{S_NS_GREEN, S_NS_YELLOW, S_ALLRED1,
                        S_EW_GREEN, S_EW_YELLOW, S_ALLRED2};
   int seq_len  [6] = '{TG, TY, TA, TG, TY, TA};

   initial begin
      // reset and power-up
      cyc();
      cyc();
      chk("rst_state", int'(state_out), S_OFF);
      chk("rst_lamps", int'({ns_red, ns_yellow, ns_green, ew_red,
                             ew_yellow, ew_green, walk, ped_pending}), 0);
      rst = 1'b0;
      enable = 1'b1;
      cyc();
      chk("pwr_allred2", int'(state_out), S_ALLRED2);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < seq_len[k]; j++) begin
            cyc();
            chk("seq", int'(state_out), seq_code[k]);
         end
      end

      // ped pulse during EW_GREEN
      wait_state(S_EW_GREEN, 40);
      ped_req = 1'b1;
      cyc();
      ped_req = 1'b0;
      chk("ped_latched", int'(ped_pending), 1);
      wait_state(S_PED_WALK, 40);
      for (int j = 0; j < TP; j++) begin
         chk("walk_on", int'(walk), 1);
         cyc();
      end
      chk("post_walk_state", int'(state_out), S_NS_GREEN);
      chk("post_walk_pend", int'(ped_pending), 0);

      // ped held through walk
      ped_req = 1'b1;
      wait_state(S_PED_WALK, 60);
      for (int j = 0; j < TP; j++) cyc();
      chk("no_relatch_state", int'(state_out), S_NS_GREEN);
      chk("no_relatch_pend", int'(ped_pending), 0);
      ped_req = 1'b0;

      // flash during NS_GREEN
      flash_mode = 1'b1;
      cyc();
      chk("flash_entry", int'(state_out), S_FLASH);
      for (int j = 0; j < 8; j++) begin
         chk("flash_ns_y", int'(ns_yellow), int'((j % 4) < 2));
         chk("flash_ew_y", int'(ew_yellow), int'((j % 4) < 2));
         cyc();
      end
      flash_mode = 1'b0;
      cyc();
      chk("flash_exit", int'(state_out), S_ALLRED2);

      // enable drop mid NS_YELLOW with pending request
      wait_state(S_NS_GREEN, 40);
      ped_req = 1'b1;
      cyc();
      ped_req = 1'b0;
      wait_state(S_NS_YELLOW, 40);
      chk("dis_pend_before", int'(ped_pending), 1);
      enable = 1'b0;
      cyc();
      chk("dis_state", int'(state_out), S_OFF);
      chk("dis_pend", int'(ped_pending), 0);
      enable = 1'b1;
      cyc();
      chk("reen_allred2", int'(state_out), S_ALLRED2);
      cyc();
      chk("reen_nsg", int'(state_out), S_NS_GREEN);

      // reset mid EW_GREEN
      wait_state(S_EW_GREEN, 40);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_state", int'(state_out), S_OFF);
      chk("midrst_outs", int'({ns_red, ns_yellow, ns_green, ew_red,
                               ew_yellow, ew_green, walk, ped_pending}), 0);

      // random run
      for (int i = 0; i < 10000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         enable = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 99) == 0) flash_mode = ~flash_mode;
         ped_req = ($urandom_range(0, 9) == 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/intersection_fsm.md
# intersection_fsm

Parametrised two-road intersection controller: the next generation of the single-lamp traffic light FSM. It drives north-south (NS) and east-west (EW) lamp sets through green/yellow/all-red phases with programmable durations, and serves a latched pedestrian request with a dedicated walk phase. It also provides a flashing-yellow degraded mode. It sits between the board-level enable/mode switches and the lamp drivers, and exposes its state for debug.

## Interface
- T_GREEN, 30: cycles per green phase (each road)
- T_YELLOW, 10: cycles per yellow phase
- T_ALLRED, 3: cycles per all-red clearance
- T_PED, 20: cycles of pedestrian walk phase
- FLASH_HALF, 5: cycles per half-period of flashing yellow
- TW, 8: timer width; must hold max(all T_*, FLASH_HALF) − 1; all T_* ≥ 1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  0 forces OFF
- flash_mode  in  1  1 forces FLASH (when enable=1)
- ped_req  in  1  pedestrian button, level or pulse, sampled each cycle
- ns_red, ns_yellow, ns_green  out  1 each  NS lamps
- ew_red, ew_yellow, ew_green  out  1 each  EW lamps
- walk  out  1  pedestrian walk lamp
- ped_pending  out  1  latched, unserved pedestrian request
- state_out  out  4  current state code (debug)

## Operation
- States (binary codes): OFF=0, NS_GREEN=1, NS_YELLOW=2, ALLRED1=3, EW_GREEN=4, EW_YELLOW=5, ALLRED2=6, PED_WALK=7, FLASH=8. Illegal codes go to OFF next cycle.
- Normal cycle: ALLRED2 → (ped_pending ? PED_WALK : NS_GREEN); PED_WALK → NS_GREEN; NS_GREEN → NS_YELLOW → ALLRED1 → EW_GREEN → EW_YELLOW → ALLRED2.
- OFF → ALLRED2 when enable=1 and flash_mode=0. Power-up therefore always begins with clearance.
- Next-state priority: rst > !enable (→OFF) > flash_mode (→FLASH) > normal transitions.
- FLASH → ALLRED2 when flash_mode=0.
- Timer: cleared on every state change and whenever enable=0. Otherwise it increments. A timed state exits in the cycle where timer == T_x − 1, so each state lasts exactly T_x cycles.
- Lamps (Moore, decoded from registered state):
  - NS_GREEN: ns_green, ew_red.
  - NS_YELLOW: ns_yellow, ew_red.
  - EW_GREEN: ew_green, ns_red.
  - EW_YELLOW: ew_yellow, ns_red.
  - ALLRED1/ALLRED2: ns_red, ew_red.
  - PED_WALK: ns_red, ew_red, walk.
  - OFF: all lamps 0.
  - FLASH: ns_yellow = ew_yellow = blink, all others 0.
- At most one lamp per road is ever 1. A green is never adjacent to any non-red lamp on the other road.
- blink: set to 1 on entry to FLASH, toggles every FLASH_HALF cycles using the timer, which wraps to 0 at each toggle.
- ped_pending: set by ped_req=1 in any state except OFF, FLASH and PED_WALK. Cleared on entry to PED_WALK and when enable=0. When set and clear coincide, clear wins.

## Timing
- Reset values: state=OFF, timer=0, ped_pending=0, blink=0; all lamps, walk and ped_pending outputs 0; state_out=0.
- Input-to-output latency: one cycle. The input is sampled on edge N, and state and lamps change after edge N.
- enable drop mid-phase: OFF and all lamps dark after the next edge. The pending request is discarded.
- Reset mid-operation is identical to a power-up reset.
- Full normal cycle without ped request: 2·T_GREEN + 2·T_YELLOW + 2·T_ALLRED cycles. A served request adds T_PED.

## Structure
- Shared package intersection_pkg: state code constants (4-bit) and default T_* values. It is reused by testbench assertions.
- One sub-module is natural: phase_timer (TW-bit counter with clear and terminal-count compare).
- The FSM, ped latch and blink live in intersection_fsm.

## Test plan
Params for all scenarios: T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_PED=3, FLASH_HALF=2.
- Reset then enable=1 → state_out 0→6→1. NS_GREEN lasts 4 cycles, NS_YELLOW 2, ALLRED1 1, EW_GREEN 4, EW_YELLOW 2, ALLRED2 1. Lamp pattern is checked every cycle.
- 1-cycle ped_req pulse during EW_GREEN → ped_pending=1 until ALLRED2 exits. Then PED_WALK for 3 cycles with walk=1, ns_red=ew_red=1, then NS_GREEN with ped_pending=0.
- ped_req held high throughout PED_WALK → not re-latched. ped_pending=0 at PED_WALK exit.
- flash_mode=1 during NS_GREEN → FLASH next cycle. ns_yellow=ew_yellow follow the pattern 1,1,0,0,1,1… and all red/green are 0. Dropping flash_mode → ALLRED2 next cycle.
- enable=0 mid NS_YELLOW with ped_pending=1 → OFF next cycle, all outputs 0, ped_pending=0. Re-enable → ALLRED2 with timer at 0.
- rst=1 asserted for one cycle mid EW_GREEN → all outputs at reset values after that edge. A continuous lamp-exclusivity assertion holds over 10,000 cycles of random enable/flash_mode/ped_req.
